// File: rtl/lcd_8080_pkg.sv
// Shared definitions for the 8080-style LCD read-back APB responder:
// FSM state encoding, APB register offsets, strobe idle levels, timer width
// and the access-legality helper used by the address decode.
package lcd_8080_pkg;

   localparam int unsigned CNT_W = 8;

   typedef logic [2:0] state_t;

   localparam state_t ST_IDLE   = 3'd0;
   localparam state_t ST_SETUP  = 3'd1;
   localparam state_t ST_STROBE = 3'd2;
   localparam state_t ST_HOLD   = 3'd3;
   localparam state_t ST_WRLOW  = 3'd4;
   localparam state_t ST_DONE   = 3'd5;

   localparam logic [1:0] ADDR_CMD    = 2'b00;
   localparam logic [1:0] ADDR_RDDATA = 2'b01;
   localparam logic [1:0] ADDR_STATUS = 2'b10;

   localparam logic CS_IDLE = 1'b1;
   localparam logic DC_IDLE = 1'b1;
   localparam logic RD_IDLE = 1'b1;
   localparam logic WR_IDLE = 1'b1;

   // CMD is write-only, RDDATA/STATUS are read-only, offset 0xC is reserved.
   function automatic logic access_legal(input logic [1:0] addr, input logic write);
      logic ok;
      case (addr)
         ADDR_CMD:    ok = write;
         ADDR_RDDATA: ok = !write;
         ADDR_STATUS: ok = !write;
         default:     ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/lcd_strobe_timer.sv
// Phase-length down-counter shared by the SETUP/STROBE/HOLD/WRLOW phases.
// Ports: clk_i, rst_ni (sync, active-low), load_i (start a phase of len_i
// cycles), len_i (phase length, >=1), expired_o (high on the phase's last cycle).
module lcd_strobe_timer
   import lcd_8080_pkg::*;
(
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             load_i,
   input  logic [CNT_W-1:0] len_i,
   output logic             expired_o
);

   logic [CNT_W-1:0] cnt_q;
   logic             expired_q;

   // Counter holds remaining cycles minus one; expired flags the final cycle.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         cnt_q     <= '0;
         expired_q <= 1'b0;
      end else if (load_i) begin
         cnt_q     <= len_i - CNT_W'(1);
         expired_q <= (len_i <= CNT_W'(1));
      end else if (cnt_q != '0) begin
         cnt_q     <= cnt_q - CNT_W'(1);
         expired_q <= (cnt_q == CNT_W'(1));
      end
   end

   assign expired_o = expired_q;

endmodule

// File: rtl/lcd_8080_rd_apb.sv
// APB3 responder that writes command bytes to and reads data bytes back from
// an 8080-style parallel LCD. CMD write sends a DC=0 byte; RDDATA read runs an
// RD-strobed cycle and returns the byte; STATUS returns the read counter.
// Ports: pclk_i/presetn_i (sync active-low reset); APB psel_i, penable_i,
// pwrite_i, paddr_i[3:2], pwdata_i[7:0], prdata_o, pready_o, pslverr_o;
// LCD data_i, data_o, data_oe_o, cs_o, dc_o, lcd_rd_o, lcd_wr_o.
// Build option: define LCD_RD_DUMMY_EN to discard one dummy byte on the first
// read after every command write.
module lcd_8080_rd_apb
   import lcd_8080_pkg::*;
#(
   parameter int unsigned G_DATA_WIDTH = 32,
   parameter int unsigned TURN_CYC     = 1,
   parameter int unsigned RD_LOW_CYC   = 4,
   parameter int unsigned RD_HIGH_CYC  = 2,
   parameter int unsigned WR_LOW_CYC   = 2
) (
   input  logic                    pclk_i,
   input  logic                    presetn_i,
   input  logic                    psel_i,
   input  logic                    penable_i,
   input  logic                    pwrite_i,
   input  logic [31:0]             paddr_i,
   input  logic [G_DATA_WIDTH-1:0] pwdata_i,
   output logic [G_DATA_WIDTH-1:0] prdata_o,
   output logic                    pready_o,
   output logic                    pslverr_o,
   input  logic [7:0]              data_i,
   output logic [7:0]              data_o,
   output logic                    data_oe_o,
   output logic                    cs_o,
   output logic                    dc_o,
   output logic                    lcd_rd_o,
   output logic                    lcd_wr_o
);

   state_t                  state_q, state_d;
   logic                    cs_q, cs_d, dc_q, dc_d, rd_q, rd_d, wr_q, wr_d, oe_q, oe_d;
   logic [7:0]              dout_q, dout_d, byte_q, byte_d;
   logic                    pready_q, pready_d, pslverr_q, pslverr_d;
   logic [G_DATA_WIDTH-1:0] prdata_q, prdata_d;
   logic [15:0]             rd_count_q, rd_count_d;
   logic                    is_wr_q, is_wr_d;
   logic                    load_c, expired;
   logic [CNT_W-1:0]        len_c;
   logic [1:0]              addr_c;
   logic                    unused_c;
`ifdef LCD_RD_DUMMY_EN
   logic                    dummy_pend_q, dummy_pend_d, extra_q, extra_d;
`endif

   assign addr_c   = paddr_i[3:2];
   assign unused_c = ^{paddr_i[31:4], paddr_i[1:0], pwdata_i[G_DATA_WIDTH-1:8]};

   lcd_strobe_timer u_timer (
      .clk_i     (pclk_i),
      .rst_ni    (presetn_i),
      .load_i    (load_c),
      .len_i     (len_c),
      .expired_o (expired)
   );

   // State and registered outputs; reset aborts any LCD cycle on the same edge.
   always_ff @(posedge pclk_i) begin
      if (!presetn_i) begin
         state_q    <= ST_IDLE;
         cs_q       <= CS_IDLE;
         dc_q       <= DC_IDLE;
         rd_q       <= RD_IDLE;
         wr_q       <= WR_IDLE;
         oe_q       <= 1'b0;
         dout_q     <= '0;
         byte_q     <= '0;
         pready_q   <= 1'b0;
         pslverr_q  <= 1'b0;
         prdata_q   <= '0;
         rd_count_q <= '0;
         is_wr_q    <= 1'b0;
`ifdef LCD_RD_DUMMY_EN
         dummy_pend_q <= 1'b0;
         extra_q      <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         cs_q       <= cs_d;
         dc_q       <= dc_d;
         rd_q       <= rd_d;
         wr_q       <= wr_d;
         oe_q       <= oe_d;
         dout_q     <= dout_d;
         byte_q     <= byte_d;
         pready_q   <= pready_d;
         pslverr_q  <= pslverr_d;
         prdata_q   <= prdata_d;
         rd_count_q <= rd_count_d;
         is_wr_q    <= is_wr_d;
`ifdef LCD_RD_DUMMY_EN
         dummy_pend_q <= dummy_pend_d;
         extra_q      <= extra_d;
`endif
      end
   end

   // Next-state and next-output logic; outputs are computed for the state being entered.
   always_comb begin
      state_d    = state_q;
      cs_d       = cs_q;
      dc_d       = dc_q;
      rd_d       = rd_q;
      wr_d       = wr_q;
      oe_d       = oe_q;
      dout_d     = dout_q;
      byte_d     = byte_q;
      pready_d   = 1'b0;
      pslverr_d  = pslverr_q;
      prdata_d   = prdata_q;
      rd_count_d = rd_count_q;
      is_wr_d    = is_wr_q;
      load_c     = 1'b0;
      len_c      = '0;
`ifdef LCD_RD_DUMMY_EN
      dummy_pend_d = dummy_pend_q;
      extra_d      = extra_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (psel_i && penable_i) begin
               pslverr_d = 1'b0;
               if (!access_legal(addr_c, pwrite_i)) begin
                  state_d   = ST_DONE;
                  pready_d  = 1'b1;
                  pslverr_d = 1'b1;
                  prdata_d  = '0;
               end else if (addr_c == ADDR_STATUS) begin
                  state_d        = ST_DONE;
                  pready_d       = 1'b1;
                  prdata_d       = '0;
                  prdata_d[15:0] = rd_count_q;
               end else if (addr_c == ADDR_CMD) begin
                  state_d = ST_WRLOW;
                  load_c  = 1'b1;
                  len_c   = CNT_W'(WR_LOW_CYC);
                  cs_d    = 1'b0;
                  dc_d    = 1'b0;
                  oe_d    = 1'b1;
                  dout_d  = pwdata_i[7:0];
                  wr_d    = 1'b0;
                  is_wr_d = 1'b1;
`ifdef LCD_RD_DUMMY_EN
                  dummy_pend_d = 1'b1;
`endif
               end else begin
                  state_d = ST_SETUP;
                  load_c  = 1'b1;
                  len_c   = CNT_W'(TURN_CYC);
                  cs_d    = 1'b0;
                  dc_d    = 1'b1;
                  oe_d    = 1'b0;
                  is_wr_d = 1'b0;
`ifdef LCD_RD_DUMMY_EN
                  extra_d      = dummy_pend_q;
                  dummy_pend_d = 1'b0;
`endif
               end
            end
         end
         ST_SETUP: begin
            if (expired) begin
               state_d = ST_STROBE;
               load_c  = 1'b1;
               len_c   = CNT_W'(RD_LOW_CYC);
               rd_d    = 1'b0;
            end
         end
         ST_STROBE: begin
            // Capture on the last low cycle, i.e. at the edge that releases RD.
            if (expired) begin
               byte_d  = data_i;
               state_d = ST_HOLD;
               load_c  = 1'b1;
               len_c   = CNT_W'(RD_HIGH_CYC);
               rd_d    = RD_IDLE;
            end
         end
         ST_WRLOW: begin
            // Data stays driven through HOLD to give the panel hold time.
            if (expired) begin
               state_d = ST_HOLD;
               load_c  = 1'b1;
               len_c   = CNT_W'(RD_HIGH_CYC);
               wr_d    = WR_IDLE;
            end
         end
         ST_HOLD: begin
            if (expired) begin
`ifdef LCD_RD_DUMMY_EN
               if (extra_q) begin
                  extra_d = 1'b0;
                  state_d = ST_STROBE;
                  load_c  = 1'b1;
                  len_c   = CNT_W'(RD_LOW_CYC);
                  rd_d    = 1'b0;
               end else
`endif
               begin
                  state_d   = ST_DONE;
                  cs_d      = CS_IDLE;
                  dc_d      = DC_IDLE;
                  oe_d      = 1'b0;
                  dout_d    = '0;
                  pready_d  = 1'b1;
                  pslverr_d = 1'b0;
                  prdata_d  = '0;
                  if (!is_wr_q) begin
                     prdata_d[7:0] = byte_q;
                     rd_count_d    = rd_count_q + 16'd1;
                  end
               end
            end
         end
         ST_DONE: begin
            state_d   = ST_IDLE;
            pslverr_d = 1'b0;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign prdata_o  = prdata_q;
   assign pready_o  = pready_q;
   assign pslverr_o = pslverr_q;
   assign data_o    = dout_q;
   assign data_oe_o = oe_q;
   assign cs_o      = cs_q;
   assign dc_o      = dc_q;
   assign lcd_rd_o  = rd_q;
   assign lcd_wr_o  = wr_q;

endmodule

// File: tb/tb_lcd_8080_rd_apb.sv
// Directed bench for lcd_8080_rd_apb: APB master tasks, a tiny LCD read model
// and strobe monitors. Latency is counted in clock edges from the edge that
// samples psel&penable in IDLE up to the edge where pready_o is seen high.
module tb_lcd_8080_rd_apb;

`ifdef LCD_RD_DUMMY_EN
   localparam int EXP_FIRST_LAT = 14;
   localparam int EXP_FIRST_STB = 2;
`else
   localparam int EXP_FIRST_LAT = 8;
   localparam int EXP_FIRST_STB = 1;
`endif

   logic        pclk = 1'b0;
   logic        presetn, psel, penable, pwrite;
   logic [31:0] paddr, pwdata, prdata_o;
   logic        pready_o, pslverr_o;
   logic [7:0]  data_i, data_o;
   logic        data_oe_o, cs_o, dc_o, lcd_rd_o, lcd_wr_o;

   int n_checks = 0;
   int n_pass   = 0;
   int n_fail   = 0;

   // Monitor counters (cumulative; the stimulus takes deltas).
   int   strobe_n = 0, rd_low_n = 0, wr_low_n = 0, oe_n = 0, cs_low_n = 0;
   int   wr_dc_bad = 0, oe_rd_bad = 0, rd_wr_bad = 0;
   logic [7:0] wr_data_seen = 8'h00;

   // LCD model: first strobe of an access returns byte_a, later ones byte_b.
   int         strobe_base = 0;
   logic [7:0] byte_a = 8'h00, byte_b = 8'h00;
   assign data_i = ((strobe_n - strobe_base) >= 2) ? byte_b : byte_a;

   always #5 pclk = ~pclk;

   lcd_8080_rd_apb dut (
      .pclk_i    (pclk),
      .presetn_i (presetn),
      .psel_i    (psel),
      .penable_i (penable),
      .pwrite_i  (pwrite),
      .paddr_i   (paddr),
      .pwdata_i  (pwdata),
      .prdata_o  (prdata_o),
      .pready_o  (pready_o),
      .pslverr_o (pslverr_o),
      .data_i    (data_i),
      .data_o    (data_o),
      .data_oe_o (data_oe_o),
      .cs_o      (cs_o),
      .dc_o      (dc_o),
      .lcd_rd_o  (lcd_rd_o),
      .lcd_wr_o  (lcd_wr_o)
   );

   always @(negedge lcd_rd_o) strobe_n++;

   always @(negedge pclk) begin
      if (lcd_rd_o === 1'b0) rd_low_n++;
      if (lcd_wr_o === 1'b0) begin
         wr_low_n++;
         wr_data_seen = data_o;
         if (dc_o !== 1'b0) wr_dc_bad++;
      end
      if (data_oe_o === 1'b1) oe_n++;
      if (cs_o === 1'b0) cs_low_n++;
      if (data_oe_o === 1'b1 && lcd_rd_o === 1'b0) oe_rd_bad++;
      if (lcd_rd_o === 1'b0 && lcd_wr_o === 1'b0) rd_wr_bad++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic apb(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                      output logic [31:0] rdata, output logic err, output int lat);
      @(negedge pclk);
      psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wdata;
      @(negedge pclk);
      penable = 1'b1;
      @(posedge pclk);
      lat = 0;
      for (int n = 1; n <= 40; n++) begin
         @(negedge pclk);
         if (pready_o === 1'b1) begin
            lat = n;
            break;
         end
      end
      rdata = prdata_o;
      err   = pslverr_o;
      @(posedge pclk);
      #1;
      psel = 1'b0; penable = 1'b0;
      @(negedge pclk);
      check("pready_single_cycle", {31'b0, pready_o}, 32'd0);
   endtask

   logic [31:0] rd;
   logic        er;
   int          lat, s0, r0, w0, o0, c0, d0;

   initial begin
      // 1: reset held with psel/penable active
      presetn = 1'b0; psel = 1'b1; penable = 1'b1; pwrite = 1'b0;
      paddr = 32'h4; pwdata = 32'h0;
      @(posedge pclk);
      for (int i = 0; i < 3; i++) begin
         @(negedge pclk);
         check("reset_strobes", {25'b0, cs_o, dc_o, lcd_rd_o, lcd_wr_o, data_oe_o, pready_o, pslverr_o},
               32'b1111000);
         check("reset_bus", {data_o, prdata_o[23:0]}, 32'h0);
      end
      psel = 1'b0; penable = 1'b0;
      @(negedge pclk);
      presetn = 1'b1;

      // 2: command write 0x04
      w0 = wr_low_n; d0 = wr_dc_bad;
      apb(1'b1, 32'h0, 32'h0000_0004, rd, er, lat);
      check("cmd_latency", lat, 32'd5);
      check("cmd_slverr", {31'b0, er}, 32'd0);
      check("cmd_wr_low_cycles", wr_low_n - w0, 32'd2);
      check("cmd_dc_low", wr_dc_bad - d0, 32'd0);
      check("cmd_data", {24'b0, wr_data_seen}, 32'h04);

      // 3: data read 0xA5 (after a command, so dummy builds run two strobes)
      byte_a = 8'hA5; byte_b = 8'hA5; strobe_base = strobe_n;
      s0 = strobe_n; r0 = rd_low_n; o0 = oe_n;
      apb(1'b0, 32'h4, 32'h0, rd, er, lat);
      check("rd_latency", lat, EXP_FIRST_LAT);
      check("rd_prdata", rd, 32'h0000_00A5);
      check("rd_slverr", {31'b0, er}, 32'd0);
      check("rd_strobes", strobe_n - s0, EXP_FIRST_STB);
      check("rd_low_cycles", rd_low_n - r0, 4 * EXP_FIRST_STB);
      check("rd_oe_quiet", oe_n - o0, 32'd0);
      apb(1'b0, 32'h8, 32'h0, rd, er, lat);
      check("status_after_rd", rd, 32'd1);
      check("status_latency", lat, 32'd1);

`ifdef LCD_RD_DUMMY_EN
      // 4: dummy byte discarded after a command write
      apb(1'b1, 32'h0, 32'h0000_0009, rd, er, lat);
      byte_a = 8'h11; byte_b = 8'h22; strobe_base = strobe_n; s0 = strobe_n;
      apb(1'b0, 32'h4, 32'h0, rd, er, lat);
      check("dummy_prdata", rd, 32'h22);
      check("dummy_latency", lat, 32'd14);
      check("dummy_strobes", strobe_n - s0, 32'd2);
      byte_a = 8'h5A; byte_b = 8'h77; strobe_base = strobe_n; s0 = strobe_n;
      apb(1'b0, 32'h4, 32'h0, rd, er, lat);
      check("dummy2_prdata", rd, 32'h5A);
      check("dummy2_latency", lat, 32'd8);
      check("dummy2_strobes", strobe_n - s0, 32'd1);
      apb(1'b0, 32'h8, 32'h0, rd, er, lat);
      check("dummy_status", rd, 32'd3);
`endif

      // 5: illegal accesses: read CMD, write STATUS, reserved 0xC, write RDDATA
      c0 = cs_low_n;
      apb(1'b0, 32'h0, 32'h0, rd, er, lat);
      check("ill_cmdrd_err", {31'b0, er}, 32'd1);
      check("ill_cmdrd_lat", lat, 32'd1);
      check("ill_cmdrd_data", rd, 32'd0);
      apb(1'b1, 32'h8, 32'hFF, rd, er, lat);
      check("ill_stwr_err", {31'b0, er}, 32'd1);
      check("ill_stwr_lat", lat, 32'd1);
      apb(1'b0, 32'hC, 32'h0, rd, er, lat);
      check("ill_resv_err", {31'b0, er}, 32'd1);
      check("ill_resv_lat", lat, 32'd1);
      apb(1'b1, 32'h4, 32'h0, rd, er, lat);
      check("ill_rdwr_err", {31'b0, er}, 32'd1);
      check("ill_cs_idle", cs_low_n - c0, 32'd0);
      apb(1'b0, 32'h8, 32'h0, rd, er, lat);
      check("legal_after_ill_err", {31'b0, er}, 32'd0);

      // 6: reset pulse during the RD strobe
      byte_a = 8'h3C; byte_b = 8'h3C; strobe_base = strobe_n;
      @(negedge pclk);
      psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 32'h4;
      @(negedge pclk);
      penable = 1'b1;
      for (int n = 0; n < 20 && lcd_rd_o !== 1'b0; n++) @(negedge pclk);
      check("rst_mid_rd_seen", {31'b0, lcd_rd_o}, 32'd0);
      presetn = 1'b0; psel = 1'b0; penable = 1'b0;
      @(posedge pclk);
      #1;
      check("rst_mid_rd_cs", {30'b0, lcd_rd_o, cs_o}, 32'b11);
      check("rst_mid_pready", {31'b0, pready_o}, 32'd0);
      @(negedge pclk);
      presetn = 1'b1;
      apb(1'b0, 32'h8, 32'h0, rd, er, lat);
      check("rst_status_zero", rd, 32'd0);
      s0 = strobe_n;
      apb(1'b0, 32'h4, 32'h0, rd, er, lat);
      check("rst_next_rd_data", rd, 32'h3C);
      check("rst_next_rd_lat", lat, 32'd8);
      check("rst_next_rd_stb", strobe_n - s0, 32'd1);

      check("oe_rd_exclusive", oe_rd_bad, 32'd0);
      check("rd_wr_exclusive", rd_wr_bad, 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
